multicycle_controller: RTL

Moore/Mealy control state machine that sequences a multicycle MIPS-subset datapath sharing one memory for instructions and data. It is the control unit for the multicycle core. It decodes the latched instruction register (opcode/funct) and drives every enable, mux select and ALU control of the datapath, one state per cycle. It also counts retired instructions and traps on unsupported encodings.

---
 rtl/multicycle_controller_if.sv | 35 +++
 rtl/multicycle_controller.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/multicycle_controller_if.sv
// Control bundle between the multicycle controller (master) and the datapath (slave).
// Carries the decoded instruction fields and every control, debug and status signal.
interface multicycle_controller_if;
  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic        zero;
  logic        memReady;
  logic        memRead;
  logic        memWrite;
  logic        iorD;
  logic        irWrite;
  logic        pcWrite;
  logic [1:0]  pcSrc;
  logic        aluSrcA;
  logic [1:0]  aluSrcB;
  logic [4:0]  aluControl;
  logic        regWrite;
  logic [1:0]  regDst;
  logic [1:0]  memToReg;
  logic        trap;
  logic [3:0]  state;
  logic [31:0] instrCount;

  modport master (
    input  opcode, funct, zero, memReady,
    output memRead, memWrite, iorD, irWrite, pcWrite, pcSrc, aluSrcA, aluSrcB,
           aluControl, regWrite, regDst, memToReg, trap, state, instrCount
  );

  modport slave (
    output opcode, funct, zero, memReady,
    input  memRead, memWrite, iorD, irWrite, pcWrite, pcSrc, aluSrcA, aluSrcB,
           aluControl, regWrite, regDst, memToReg, trap, state, instrCount
  );
endinterface

// File: rtl/multicycle_controller.sv
// Control FSM for the shared-memory multicycle MIPS-subset core, with retired-instruction
// counter and illegal-instruction trap. Define MCC_WAIT_EN to stall memory states on memReady.
module multicycle_controller (
  input  logic                       clock,
  input  logic                       resetN,
  multicycle_controller_if.master    bus
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,  S_DECODE = 4'd1,  S_MEMADR = 4'd2,  S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,  S_MEMWR  = 4'd5,  S_RTEXEC = 4'd6,  S_RTWB   = 4'd7,
    S_BRANCH = 4'd8,  S_ADDIEX = 4'd9,  S_ADDIWB = 4'd10, S_JUMP   = 4'd11,
    S_JR     = 4'd12, S_TRAP   = 4'd15
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;
  localparam logic [5:0] FN_JR  = 6'b001000;

  localparam logic [4:0] ALU_ADD = 5'b00010;
  localparam logic [4:0] ALU_SUB = 5'b00110;
  localparam logic [4:0] ALU_AND = 5'b00000;
  localparam logic [4:0] ALU_OR  = 5'b00001;
  localparam logic [4:0] ALU_SLT = 5'b00111;

  state_t      state_reg, state_next;
  logic [31:0] count_reg;
  logic        mem_ready;

  logic        mem_read_c, mem_write_c, iord_c, ir_write_c, pc_write_c;
  logic        alu_src_a_c, reg_write_c, trap_c;
  logic [1:0]  pc_src_c, alu_src_b_c, reg_dst_c, mem_to_reg_c;
  logic [4:0]  alu_control_c;

`ifdef MCC_WAIT_EN
  assign mem_ready = bus.memReady;
`else
  assign mem_ready = 1'b1;
`endif

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      state_reg <= S_FETCH;
      count_reg <= 32'd0;
    end else begin
      state_reg <= state_next;
      // Retirement is any return to FETCH; TRAP never returns, so the count freezes there.
      if (state_reg != S_FETCH && state_next == S_FETCH)
        count_reg <= count_reg + 32'd1;
    end
  end

  always_comb begin
    state_next    = state_reg;
    mem_read_c    = 1'b0;
    mem_write_c   = 1'b0;
    iord_c        = 1'b0;
    ir_write_c    = 1'b0;
    pc_write_c    = 1'b0;
    pc_src_c      = 2'b00;
    alu_src_a_c   = 1'b0;
    alu_src_b_c   = 2'b00;
    alu_control_c = ALU_ADD;
    reg_write_c   = 1'b0;
    reg_dst_c     = 2'b00;
    mem_to_reg_c  = 2'b00;
    trap_c        = 1'b0;

    case (state_reg)
      S_FETCH: begin
        mem_read_c  = 1'b1;
        ir_write_c  = mem_ready;
        pc_write_c  = mem_ready;
        alu_src_b_c = 2'b01;
        if (mem_ready) state_next = S_DECODE;
      end
      S_DECODE: begin
        alu_src_b_c = 2'b11;
        case (bus.opcode)
          OP_LW, OP_SW: state_next = S_MEMADR;
          OP_RTYPE: begin
            case (bus.funct)
              FN_JR:                                  state_next = S_JR;
              FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT:  state_next = S_RTEXEC;
              default:                                state_next = S_TRAP;
            endcase
          end
          OP_BEQ:       state_next = S_BRANCH;
          OP_ADDI:      state_next = S_ADDIEX;
          OP_J, OP_JAL: state_next = S_JUMP;
          default:      state_next = S_TRAP;
        endcase
      end
      S_MEMADR: begin
        alu_src_a_c = 1'b1;
        alu_src_b_c = 2'b10;
        state_next  = (bus.opcode == OP_SW) ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        mem_read_c = 1'b1;
        iord_c     = 1'b1;
        if (mem_ready) state_next = S_MEMWB;
      end
      S_MEMWB: begin
        reg_write_c  = 1'b1;
        mem_to_reg_c = 2'b01;
        state_next   = S_FETCH;
      end
      S_MEMWR: begin
        mem_write_c = 1'b1;
        iord_c      = 1'b1;
        if (mem_ready) state_next = S_FETCH;
      end
      S_RTEXEC: begin
        alu_src_a_c = 1'b1;
        case (bus.funct)
          FN_SUB:  alu_control_c = ALU_SUB;
          FN_AND:  alu_control_c = ALU_AND;
          FN_OR:   alu_control_c = ALU_OR;
          FN_SLT:  alu_control_c = ALU_SLT;
          default: alu_control_c = ALU_ADD;
        endcase
        state_next = S_RTWB;
      end
      S_RTWB: begin
        reg_write_c = 1'b1;
        reg_dst_c   = 2'b01;
        state_next  = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a_c   = 1'b1;
        alu_control_c = ALU_SUB;
        pc_src_c      = 2'b01;
        pc_write_c    = bus.zero;
        state_next    = S_FETCH;
      end
      S_ADDIEX: begin
        alu_src_a_c = 1'b1;
        alu_src_b_c = 2'b10;
        state_next  = S_ADDIWB;
      end
      S_ADDIWB: begin
        reg_write_c = 1'b1;
        state_next  = S_FETCH;
      end
      S_JUMP: begin
        pc_src_c   = 2'b10;
        pc_write_c = 1'b1;
        // jal links the PC+4 already written back during FETCH.
        if (bus.opcode == OP_JAL) begin
          reg_write_c  = 1'b1;
          reg_dst_c    = 2'b10;
          mem_to_reg_c = 2'b10;
        end
        state_next = S_FETCH;
      end
      S_JR: begin
        pc_src_c   = 2'b11;
        pc_write_c = 1'b1;
        state_next = S_FETCH;
      end
      S_TRAP: begin
        trap_c     = 1'b1;
        state_next = S_TRAP;
      end
      default: state_next = S_TRAP;
    endcase
  end

  // Strobes are gated by resetN so an asserted reset blocks any write in the same cycle.
  assign bus.memRead    = mem_read_c  & resetN;
  assign bus.memWrite   = mem_write_c & resetN;
  assign bus.irWrite    = ir_write_c  & resetN;
  assign bus.pcWrite    = pc_write_c  & resetN;
  assign bus.regWrite   = reg_write_c & resetN;
  assign bus.iorD       = iord_c;
  assign bus.pcSrc      = pc_src_c;
  assign bus.aluSrcA    = alu_src_a_c;
  assign bus.aluSrcB    = alu_src_b_c;
  assign bus.aluControl = alu_control_c;
  assign bus.regDst     = reg_dst_c;
  assign bus.memToReg   = mem_to_reg_c;
  assign bus.trap       = trap_c;
  assign bus.state      = state_reg;
  assign bus.instrCount = count_reg;

endmodule
